tlb_ctrl: RTL
=============

# tlb_ctrl

Maintenance controller and miss recorder for the 8-entry TLB. It receives TLB-write and flush commands from the writeback stage and sequences them onto the TLB write port (`we`, `read_addr`, `write_data`), stalling the pipeline while busy. It also arbitrates the two lookup ports' miss exceptions into a single faulting-address record that the trap handler reads and acknowledges.

## Interface
- `ENTRIES`, 8: number of TLB slots, which is also the flush length.
- `PPN_W`, 6: physical page number width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command (high only in IDLE).
- `cmd_op` in 2: 1 = WRITE, 2 = FLUSH_ALL; 0 and 3 are reserved.
- `cmd_key` in 32: {pid[11:0], vpn[19:0]} for WRITE.
- `cmd_ppn` in PPN_W: PPN for WRITE.
- `busy` out 1: pipeline stall, equal to `state != IDLE`.
- `done` out 1: one-cycle pulse on the last TLB write of a command.
- `tlb_we` out 1: drives the TLB `we`.
- `tlb_key` out 32: drives the TLB `read_addr` (write key).
- `tlb_wdata` out 32: drives the TLB `write_data`; bits [31:PPN_W] are 0.
- `kmode` in 1: current privilege.
- `pid` in 12: current process ID.
- `v0` in 1: port 0 (fetch) lookup is live.
- `v1` in 1: port 1 (memory) lookup is live.
- `addr0` in 32: port 0 virtual address.
- `addr1` in 32: port 1 virtual address.
- `exc0` in 8: TLB `exc_out0`.
- `exc1` in 8: TLB `exc_out1`.
- `miss_pending` out 1: a miss is recorded.
- `miss_cause` out 8: recorded cause (0x82 umiss, 0x83 kmiss).
- `miss_vaddr` out 32: recorded faulting virtual address.
- `miss_pid` out 12: recorded pid.
- `miss_ack` in 1: handler consumed the record.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. A handshake moves to WRITE (op 1) or FLUSH (op 2). A reserved op is consumed, leaves the state in IDLE and pulses `done` on the next cycle with no write.
  - WRITE: one cycle. `tlb_we`=1, `tlb_key`=latched key, `tlb_wdata`={0, latched ppn}, `done`=1. Next state is IDLE.
  - FLUSH: counter `cnt` runs 0..ENTRIES-1. Each cycle drives `tlb_we`=1, `tlb_key`={12'hFFF, 17'd0, cnt[2:0]}, `tlb_wdata`=0. `done`=1 when `cnt`=ENTRIES-1, then IDLE and `cnt` returns to 0.
- Pid 0xFFF is reserved: it is never a live pid, so flushed keys never hit. The TLB's round-robin victim pointer advances once per write, so exactly ENTRIES writes overwrite every slot whatever the pointer's starting value.
- Command fields are latched at handshake; inputs are ignored while busy.
- Miss capture, only while `miss_pending`=0:
  - Candidates: port 1 if `v1` and `exc1` ∈ {0x82, 0x83}; port 0 if `v0` and `exc0` ≠ 0.
  - Port 1 wins when both are candidates, because it is the older instruction.
  - Capture records cause, address and `pid`, and sets `miss_pending`.
- While `miss_pending`=1 the record is frozen and new misses are dropped, since the pipeline is already trapping.
- `miss_ack` clears `miss_pending` on the next edge. A simultaneous ack and new miss: the ack clears the old record and the new miss is captured on the same edge.

## Timing
- Reset values:
  - `state`=IDLE, `cnt`=0.
  - `cmd_ready`=1, `busy`=0, `done`=0, `tlb_we`=0, `tlb_key`=0, `tlb_wdata`=0.
  - `miss_pending`=0, `miss_cause`=0, `miss_vaddr`=0, `miss_pid`=0.
- All outputs are registered or decoded directly from state; there is no combinational path from `cmd_*` to `tlb_*`.
- WRITE accepted at edge N: `tlb_we` is high in cycle N+1 and `cmd_ready` returns in cycle N+2.
- FLUSH accepted at edge N: `tlb_we` is high in cycles N+1..N+8, `done` in N+8, `cmd_ready` returns in N+9.
- Miss capture takes 1 cycle: the miss is present at edge N and `miss_*` is valid from N+1.
- Reset mid-FLUSH aborts immediately. `tlb_we` drops the next cycle, no `done` is issued, and the partial flush stands. Software reissues the command.

## Structure
- `tlb_pkg`:
  - op codes: `TLB_OP_WRITE`, `TLB_OP_FLUSH`.
  - `TLB_INVALID_PID`=12'hFFF.
  - `TLB_ENTRIES`=8.
  - exception codes `EXC_UMISS`=8'h82, `EXC_KMISS`=8'h83.
  - FSM state enum.
- Sub-module `tlb_miss_capture` holds the priority select plus the record and pending registers. The FSM stays in `tlb_ctrl`.

## Test plan
- Reset, then WRITE with key 0x00100040 and ppn 0x15 → `tlb_we` for exactly one cycle with `tlb_key`=0x00100040 and `tlb_wdata`=0x15; `done` in the same cycle; `cmd_ready`=1 two cycles after acceptance.
- FLUSH_ALL → eight consecutive cycles of `tlb_we`, keys 0xFFF00000..0xFFF00007, `wdata`=0; `done` on the 8th; `busy` high throughout. A `cmd_valid` held during the flush is not accepted until cycle N+9.
- Port 0 miss 0x82 at `addr0`=0x00403008 with `v0`=1 → `miss_pending`, `miss_cause`=0x82, `miss_vaddr`=0x00403008, `miss_pid`=`pid`. A later port-1 miss before `miss_ack` leaves the record unchanged.
- Simultaneous port-0 miss 0x82 and port-1 miss 0x83 with `kmode`=1 → port 1 is recorded with cause 0x83. `miss_ack` together with a new port-0 miss → the new record is captured and `miss_pending` stays 1.
- `rst` asserted in the 4th FLUSH cycle → `tlb_we`=0 and `cmd_ready`=1 the next cycle, no `done`. A following WRITE proceeds normally.
- Reserved op 3 → no `tlb_we`, one `done` pulse, state back to IDLE.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared constants, op codes and FSM state type for the TLB maintenance controller.
package tlb_pkg;

  localparam int          TLB_ENTRIES     = 8;
  localparam logic [11:0] TLB_INVALID_PID = 12'hFFF;

  localparam logic [1:0]  TLB_OP_WRITE = 2'd1;
  localparam logic [1:0]  TLB_OP_FLUSH = 2'd2;

  localparam logic [7:0]  EXC_UMISS = 8'h82;
  localparam logic [7:0]  EXC_KMISS = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } tlb_state_e;

  function automatic logic is_miss(input logic [7:0] exc);
    return (exc == EXC_UMISS) || (exc == EXC_KMISS);
  endfunction

endpackage

// File: rtl/tlb_miss_capture.sv
// Picks the older faulting lookup (port 1 over port 0) and holds it until the trap handler acks.
module tlb_miss_capture
  import tlb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        v0,
  input  logic        v1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [7:0]  exc0,
  input  logic [7:0]  exc1,
  input  logic [11:0] pid,
  input  logic        miss_ack,
  output logic        miss_pending,
  output logic [7:0]  miss_cause,
  output logic [31:0] miss_vaddr,
  output logic [11:0] miss_pid
);

  logic        cand0;
  logic        cand1;
  logic        open_slot;
  logic        capture;
  logic [7:0]  sel_cause;
  logic [31:0] sel_vaddr;

  assign cand0     = v0 && (exc0 != 8'h00);
  assign cand1     = v1 && is_miss(exc1);
  // An ack on the same edge frees the slot so a back-to-back miss is not lost.
  assign open_slot = !miss_pending || miss_ack;
  assign capture   = open_slot && (cand0 || cand1);

  always_comb begin
    sel_cause = exc0;
    sel_vaddr = addr0;
    if (cand1) begin
      sel_cause = exc1;
      sel_vaddr = addr1;
    end
  end

  // Record stage: cause/address/pid registered on capture, frozen while pending
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_pending <= 1'b0;
      miss_cause   <= 8'h00;
      miss_vaddr   <= 32'h0;
      miss_pid     <= 12'h000;
    end else if (capture) begin
      miss_pending <= 1'b1;
      miss_cause   <= sel_cause;
      miss_vaddr   <= sel_vaddr;
      miss_pid     <= pid;
    end else if (miss_ack) begin
      miss_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer (single write / full flush) plus lookup-miss recorder.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int PPN_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_key,
  input  logic [PPN_W-1:0] cmd_ppn,
  output logic             busy,
  output logic             done,
  output logic             tlb_we,
  output logic [31:0]      tlb_key,
  output logic [31:0]      tlb_wdata,
  input  logic             kmode,
  input  logic [11:0]      pid,
  input  logic             v0,
  input  logic             v1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [7:0]       exc0,
  input  logic [7:0]       exc1,
  output logic             miss_pending,
  output logic [7:0]       miss_cause,
  output logic [31:0]      miss_vaddr,
  output logic [11:0]      miss_pid,
  input  logic             miss_ack
);

  localparam int CNT_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  tlb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      key_p0;
  logic [PPN_W-1:0] ppn_p0;
  logic             rsv_done_p0;
  logic             accept;
  logic             reserved_op;
  logic             last_flush;
  logic             unused_kmode;

  // The TLB itself resolves privilege into the exc codes; nothing here needs it.
  assign unused_kmode = kmode;

  assign accept      = cmd_valid && (state == ST_IDLE);
  assign reserved_op = (cmd_op != TLB_OP_WRITE) && (cmd_op != TLB_OP_FLUSH);
  assign last_flush  = (state == ST_FLUSH) && (cnt == CNT_W'(ENTRIES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rsv_done_p0 <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rsv_done_p0 <= accept && reserved_op;
    end
  end

  // Command latch stage: fields held for the duration of the command
  always_ff @(posedge clk) begin
    if (accept) begin
      key_p0 <= cmd_key;
      ppn_p0 <= cmd_ppn;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && (cmd_op == TLB_OP_WRITE)) begin
          state_nxt = ST_WRITE;
        end else if (accept && (cmd_op == TLB_OP_FLUSH)) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = '0;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_FLUSH: begin
        if (last_flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Every flush write targets the reserved pid, so the overwritten slots can never hit.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    tlb_we    = (state != ST_IDLE);
    done      = (state == ST_WRITE) || last_flush || rsv_done_p0;
    tlb_key   = 32'h0;
    tlb_wdata = 32'h0;
    case (state)
      ST_WRITE: begin
        tlb_key   = key_p0;
        tlb_wdata = 32'(ppn_p0);
      end
      ST_FLUSH: tlb_key = {TLB_INVALID_PID, 20'(cnt)};
      default: ;
    endcase
  end

  tlb_miss_capture u_miss (
    .clk          (clk),
    .rst          (rst),
    .v0           (v0),
    .v1           (v1),
    .addr0        (addr0),
    .addr1        (addr1),
    .exc0         (exc0),
    .exc1         (exc1),
    .pid          (pid),
    .miss_ack     (miss_ack),
    .miss_pending (miss_pending),
    .miss_cause   (miss_cause),
    .miss_vaddr   (miss_vaddr),
    .miss_pid     (miss_pid)
  );

endmodule
